// File: rtl/fp8_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fp8_accumulator
// Brief    : Sequential E4M3 (bias 7) accumulator with valid/ready streaming
//            input and a held output handshake carrying the final stream sum.
//            Define FP8_ACC_ROUND_EN for round-to-nearest-even normalization;
//            otherwise results truncate.
// Revision : 1.0 - initial release
// ============================================================================
module fp8_accumulator (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ALIGN = 3'd1;
    localparam logic [2:0] c_ADD   = 3'd2;
    localparam logic [2:0] c_NORM  = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

`ifdef FP8_ACC_ROUND_EN
    localparam logic c_ROUND_EN = 1'b1;
`else
    localparam logic c_ROUND_EN = 1'b0;
`endif

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [7:0] r_acc;
    logic [7:0] r_b;
    logic       r_last;
    logic [6:0] r_sig_a;
    logic [6:0] r_sig_b;
    logic [3:0] r_exp;
    logic       r_sign;
    logic       r_sub;
    logic       r_sticky;
    logic [7:0] r_sum;

    logic              w_acc_larger;
    logic [7:0]        w_lg;
    logic [7:0]        w_sm;
    logic [6:0]        w_sig_lg;
    logic [6:0]        w_sig_sm;
    logic [3:0]        w_d;
    logic [6:0]        w_sig_sh;
    logic [6:0]        w_mask;
    logic              w_stk_align;
    logic [2:0]        w_lz;
    logic [5:0]        w_norm;
    logic              w_stk;
    logic signed [5:0] w_exp_base;
    logic signed [5:0] w_exp_n;
    logic signed [5:0] w_exp_r;
    logic              w_up;
    logic [3:0]        w_mant_inc;
    logic [7:0]        w_result;

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (in_valid) w_next_state = c_ALIGN;
            c_ALIGN: w_next_state = c_ADD;
            c_ADD:   w_next_state = c_NORM;
            c_NORM:  w_next_state = r_last ? c_DONE : c_IDLE;
            c_DONE:  if (out_ready) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Ready is held low while rst is asserted so the reset cycle never advertises space.
    assign in_ready  = (r_state == c_IDLE) && !rst;
    assign out_valid = (r_state == c_DONE);
    assign out_data  = (r_state == c_DONE) ? r_acc : 8'h00;

    // Magnitude order on {exp,mant}; ties keep the accumulator as the larger operand.
    always_comb begin
        w_acc_larger = (r_acc[6:0] >= r_b[6:0]);
        w_lg         = w_acc_larger ? r_acc : r_b;
        w_sm         = w_acc_larger ? r_b : r_acc;
        w_sig_lg     = (w_lg[6:3] != 4'd0) ? {1'b1, w_lg[2:0], 3'b000} : 7'd0;
        w_sig_sm     = (w_sm[6:3] != 4'd0) ? {1'b1, w_sm[2:0], 3'b000} : 7'd0;
        w_d          = w_lg[6:3] - w_sm[6:3];
        w_sig_sh     = w_sig_sm >> w_d;
        w_mask       = ~(7'h7F << w_d);
        w_stk_align  = |(w_sig_sm & w_mask);
    end

    always_comb begin
        w_lz = 3'd0;
        casez (r_sum[6:0])
            7'b1??????: w_lz = 3'd0;
            7'b01?????: w_lz = 3'd1;
            7'b001????: w_lz = 3'd2;
            7'b0001???: w_lz = 3'd3;
            7'b00001??: w_lz = 3'd4;
            7'b000001?: w_lz = 3'd5;
            7'b0000001: w_lz = 3'd6;
            default:    w_lz = 3'd0;
        endcase
    end

    // Only the six bits below the hidden one are needed after normalization.
    always_comb begin
        w_exp_base = $signed({2'b00, r_exp});
        if (r_sum[7]) begin
            w_norm  = r_sum[6:1];
            w_stk   = r_sticky | r_sum[0];
            w_exp_n = w_exp_base + 6'sd1;
        end else begin
            w_norm  = r_sum[5:0] << w_lz;
            w_stk   = r_sticky;
            w_exp_n = w_exp_base - $signed({3'b000, w_lz});
        end
        w_up       = c_ROUND_EN & w_norm[2] & ((|w_norm[1:0]) | w_stk | w_norm[3]);
        w_mant_inc = {1'b0, w_norm[5:3]} + {3'b000, w_up};
        w_exp_r    = w_exp_n + $signed({5'b00000, w_mant_inc[3]});
        if (r_sum == 8'd0)          w_result = 8'h00;
        else if (w_exp_r > 6'sd15)  w_result = {r_sign, 7'h7F};
        else if (w_exp_r < 6'sd1)   w_result = 8'h00;
        else                        w_result = {r_sign, w_exp_r[3:0], w_mant_inc[2:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= 8'h00;
            r_b      <= 8'h00;
            r_last   <= 1'b0;
            r_sig_a  <= 7'd0;
            r_sig_b  <= 7'd0;
            r_exp    <= 4'd0;
            r_sign   <= 1'b0;
            r_sub    <= 1'b0;
            r_sticky <= 1'b0;
            r_sum    <= 8'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_b    <= in_data;
                        r_last <= in_last;
                    end
                end
                c_ALIGN: begin
                    r_sig_a  <= w_sig_lg;
                    r_sig_b  <= w_sig_sh;
                    r_exp    <= w_lg[6:3];
                    r_sign   <= w_lg[7];
                    r_sub    <= w_lg[7] ^ w_sm[7];
                    r_sticky <= w_stk_align;
                end
                c_ADD: begin
                    r_sum <= r_sub ? {1'b0, r_sig_a - r_sig_b}
                                   : {1'b0, r_sig_a} + {1'b0, r_sig_b};
                end
                c_NORM: r_acc <= w_result;
                c_DONE: if (out_ready) r_acc <= 8'h00;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
